// File: rtl/ram_clr_pkg.sv
// ram_clr_pkg: typed views of the shared RAM definitions plus small
// width helpers used by ram_clr and ram_clr_ctrl.
package ram_clr_pkg;

`include "ram_defs.vh"

  // Controller state, encoded from the shared include file
  typedef enum logic {
    ST_IDLE  = `RAM_ST_IDLE,
    ST_SWEEP = `RAM_ST_SWEEP
  } state_e;

  localparam int DEF_WIDTH     = `RAM_DEF_WIDTH;
  localparam int DEF_ADDR_BITS = `RAM_DEF_ADDR_BITS;
  localparam int DEF_DEPTH     = `RAM_DEF_DEPTH;

  // Sweep pointer width: must be able to hold DEPTH itself so the
  // pointer never wraps while stepping through the last word.
  function automatic int ptr_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Index width for the storage array (at least one bit).
  function automatic int mem_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_clr_ctrl.sv
// ram_clr_ctrl: clear-sweep controller for ram_clr.
// With RAM_CLR_SWEEP_EN defined this is a two-state FSM (IDLE/SWEEP) with
// a word pointer that walks the memory writing zeros after reset or a
// clear request. Without RAM_CLR_SWEEP_EN only a ready flag remains: it is
// dropped by reset and raised on the first edge without reset; clear is
// ignored and the sweep write port is tied off.
module ram_clr_ctrl
  import ram_clr_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  output logic             ready,
  output logic             sweep_we,
  output logic [PTR_W-1:0] sweep_addr
);

`ifdef RAM_CLR_SWEEP_EN

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_next;

  // State register: reset always (re)starts a sweep
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_SWEEP;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and pointer: clear only acts from IDLE, so a clear during
  // a sweep neither restarts nor extends it
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (clear) begin
          w_state_next = ST_SWEEP;
          w_ptr_next   = '0;
        end
      end
      ST_SWEEP: begin
        w_ptr_next = r_ptr + PTR_W'(1);
        if (r_ptr == LAST_PTR) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_SWEEP;
        w_ptr_next   = '0;
      end
    endcase
  end

  // Pointer register: held at zero for as long as reset is asserted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  // Outputs: a reset edge writes nothing, it only rewinds the sweep
  always_comb begin
    ready      = (r_state == ST_IDLE);
    sweep_we   = (r_state == ST_SWEEP) && !reset;
    sweep_addr = r_ptr;
  end

`else

  logic r_ready;
  logic w_unused_clear;

  // Ready flag: low across reset, high from the first edge without it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b1;
    end
  end

  // No sweep hardware: the write port towards the array is tied off
  always_comb begin
    ready      = r_ready;
    sweep_we   = 1'b0;
    sweep_addr = '0;
  end

  assign w_unused_clear = clear;

`endif

endmodule

// File: rtl/ram_defs.vh
// Shared RAM definitions: FSM state encodings and default geometry.
// Kept in a plain include file so other RAM variants can reuse them.
`ifndef RAM_DEFS_VH
`define RAM_DEFS_VH

// Controller state encodings (one bit is enough for two states)
`define RAM_ST_IDLE       1'b0
`define RAM_ST_SWEEP      1'b1

// Default geometry
`define RAM_DEF_WIDTH     16
`define RAM_DEF_ADDR_BITS 6
`define RAM_DEF_DEPTH     64

`endif

// File: rtl/ram_clr.sv
// ram_clr: single-port RAM with combinational read and a zero-fill sweep.
// Holds the storage array, the write-port mux (host write vs. sweep
// write) and the read mux. The sweep controller lives in ram_clr_ctrl.
// Optional feature macro: RAM_CLR_SWEEP_EN (sweep state, pointer and the
// clear function). The port list is the same with or without it.
module ram_clr
  import ram_clr_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DEPTH     = DEF_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 load,
  input  logic [ADDR_BITS-1:0] address,
  input  logic [WIDTH-1:0]     in,
  output logic [WIDTH-1:0]     out,
  output logic                 ready
);

  localparam int PTR_W  = ptr_width(DEPTH);
  localparam int MEM_AW = mem_aw(DEPTH);
  // One extra bit so that DEPTH == 2**ADDR_BITS is representable
  localparam logic [ADDR_BITS:0] DEPTH_LIM = (ADDR_BITS + 1)'(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic              w_ready;
  logic              w_sweep_we;
  logic [PTR_W-1:0]  w_sweep_addr;
  logic              w_addr_ok;
  logic              w_host_we;
  logic              w_we;
  logic [MEM_AW-1:0] w_wr_idx;
  logic [WIDTH-1:0]  w_wr_data;
  logic [MEM_AW-1:0] w_rd_idx;

  ram_clr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .ready      (w_ready),
    .sweep_we   (w_sweep_we),
    .sweep_addr (w_sweep_addr)
  );

  assign ready = w_ready;

  // Addresses beyond the implemented words neither write nor read
  assign w_addr_ok = ({1'b0, address} < DEPTH_LIM);

  // Write-port mux: the sweep owns the port whenever ready is low, so the
  // two sources never compete; clear beats a same-cycle load
  always_comb begin
    w_host_we = w_ready && load && !reset && w_addr_ok;
`ifdef RAM_CLR_SWEEP_EN
    w_host_we = w_host_we && !clear;
`endif
    w_we      = w_sweep_we || w_host_we;
    w_wr_idx  = w_sweep_we ? MEM_AW'(w_sweep_addr) : MEM_AW'(address);
    w_wr_data = w_sweep_we ? '0 : in;
  end

  // Storage array: contents are never touched by reset directly
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_wr_idx] <= w_wr_data;
    end
  end

  assign w_rd_idx = MEM_AW'(address);

  // Read mux: zero while busy or for an unimplemented address
  always_comb begin
    out = '0;
    if (w_ready && w_addr_ok) begin
      out = r_mem[w_rd_idx];
    end
  end

endmodule

// File: tb/tb_ram_clr.sv
// tb_ram_clr: directed bench for ram_clr. Instance A uses the default
// geometry (64 words), instance B uses DEPTH=20 with ADDR_BITS=6.
// Follows the RAM_CLR_SWEEP_EN setting of the build.
module tb_ram_clr;

  typedef struct {
    int          sel;
    logic        load;
    logic        clr;
    logic [5:0]  addr;
    logic [15:0] din;
    logic [15:0] exp_out;
    logic        exp_rdy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_a = 1'b0, load_a = 1'b0;
  logic [5:0]  addr_a = '0;
  logic [15:0] din_a = '0;
  logic [15:0] out_a;
  logic        rdy_a;
  logic        clr_b = 1'b0, load_b = 1'b0;
  logic [5:0]  addr_b = '0;
  logic [15:0] din_b = '0;
  logic [15:0] out_b;
  logic        rdy_b;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  ram_clr u_dut_a (
    .clk     (clk),
    .reset   (rst),
    .clear   (clr_a),
    .load    (load_a),
    .address (addr_a),
    .in      (din_a),
    .out     (out_a),
    .ready   (rdy_a)
  );

  ram_clr #(
    .WIDTH     (16),
    .ADDR_BITS (6),
    .DEPTH     (20)
  ) u_dut_b (
    .clk     (clk),
    .reset   (rst),
    .clear   (clr_b),
    .load    (load_b),
    .address (addr_b),
    .in      (din_b),
    .out     (out_b),
    .ready   (rdy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input int sel, input logic ld, input logic cl,
                              input logic [5:0] a, input logic [15:0] d,
                              input logic [15:0] eo, input logic er);
    vec_t v;
    v.sel = sel; v.load = ld; v.clr = cl; v.addr = a;
    v.din = d; v.exp_out = eo; v.exp_rdy = er;
    vecs.push_back(v);
  endfunction

  // Counts edges until each instance is ready again (bounded)
  task automatic sweep_count(output int na, output int nb);
    na = -1;
    nb = -1;
    for (int n = 1; n <= 200 && (na < 0 || nb < 0); n++) begin
      tick();
      if (na < 0 && rdy_a === 1'b1) na = n;
      if (nb < 0 && rdy_b === 1'b1) nb = n;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nb;

    // sel, load, clear, addr, din, expected out, expected ready
    add(0, 1, 0,  7, 16'h0042, 16'h0042, 1);
    add(0, 1, 0,  0, 16'hAAAA, 16'hAAAA, 1);
    add(0, 1, 0, 63, 16'h5555, 16'h5555, 1);
    add(0, 1, 0,  5, 16'h1234, 16'h1234, 1);
    add(0, 0, 0,  7, 16'hFFFF, 16'h0042, 1);
    add(0, 0, 0,  0, 16'hFFFF, 16'hAAAA, 1);
    add(1, 1, 0, 19, 16'hBEEF, 16'hBEEF, 1);
    add(1, 1, 0, 25, 16'hDEAD, 16'h0000, 1);
    add(1, 1, 0, 51, 16'hDEAD, 16'h0000, 1);
    add(1, 0, 0, 19, 16'h0000, 16'hBEEF, 1);
    add(1, 1, 0,  0, 16'h0101, 16'h0101, 1);
    add(1, 0, 0, 25, 16'h0000, 16'h0000, 1);
    add(1, 0, 0, 19, 16'h0000, 16'hBEEF, 1);
`ifdef RAM_CLR_SWEEP_EN
    add(0, 0, 0,  6, 16'h0000, 16'h0000, 1);
    add(0, 0, 0, 62, 16'h0000, 16'h0000, 1);
`else
    add(0, 1, 1, 10, 16'h1111, 16'h1111, 1);
    add(0, 0, 0,  5, 16'h0000, 16'h1234, 1);
`endif

    // Reset held for two edges
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("rst%0d_rdy_a", i), rdy_a, 0);
      check($sformatf("rst%0d_out_a", i), out_a, 0);
      check($sformatf("rst%0d_rdy_b", i), rdy_b, 0);
    end
    rst = 1'b0;

`ifdef RAM_CLR_SWEEP_EN
    sweep_count(na, nb);
    check("rst_sweep_edges_a", na, 64);
    check("rst_sweep_edges_b", nb, 20);
    for (int i = 0; i < 64; i++) begin
      addr_a = 6'(i);
      #1;
      check($sformatf("zero_a[%0d]", i), out_a, 0);
    end
`else
    tick();
    check("rel_rdy_a", rdy_a, 1);
    check("rel_rdy_b", rdy_b, 1);
`endif

    // Table-driven single-edge transactions
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].sel == 0) begin
        load_a = vecs[i].load; clr_a = vecs[i].clr;
        addr_a = vecs[i].addr; din_a = vecs[i].din;
      end else begin
        load_b = vecs[i].load; clr_b = vecs[i].clr;
        addr_b = vecs[i].addr; din_b = vecs[i].din;
      end
      tick();
      if (vecs[i].sel == 0) begin
        check($sformatf("vec%0d_out", i), out_a, vecs[i].exp_out);
        check($sformatf("vec%0d_rdy", i), rdy_a, vecs[i].exp_rdy);
      end else begin
        check($sformatf("vec%0d_out", i), out_b, vecs[i].exp_out);
        check($sformatf("vec%0d_rdy", i), rdy_b, vecs[i].exp_rdy);
      end
      load_a = 0; clr_a = 0; load_b = 0; clr_b = 0;
    end

`ifdef RAM_CLR_SWEEP_EN
    // clear and load together: clear wins, re-pulsed clear does not extend
    clr_a = 1; load_a = 1; addr_a = 3; din_a = 16'h00FF;
    tick();
    check("clr_start_rdy", rdy_a, 0);
    check("clr_start_out", out_a, 0);
    clr_a = 0; load_a = 0; addr_a = 7;
    na = -1;
    for (int n = 1; n <= 200 && na < 0; n++) begin
      clr_a  = (n == 10);
      load_a = (n == 20);
      if (n == 20) begin addr_a = 5; din_a = 16'h9999; end
      tick();
      if (n == 5) check("busy_out_zero", out_a, 0);
      if (rdy_a === 1'b1) na = n;
    end
    clr_a = 0; load_a = 0;
    check("clr_sweep_edges", na, 64);
    addr_a = 3;  #1; check("clr_addr3", out_a, 0);
    addr_a = 5;  #1; check("clr_addr5", out_a, 0);
    addr_a = 7;  #1; check("clr_addr7", out_a, 0);
    addr_a = 63; #1; check("clr_addr63", out_a, 0);

    // Reset at sweep edge 30 restarts the sweep
    load_a = 1; addr_a = 9; din_a = 16'h0909;
    tick();
    check("wr_addr9", out_a, 16'h0909);
    load_a = 0;
    clr_a = 1;
    tick();
    clr_a = 0;
    for (int n = 1; n < 30; n++) tick();
    check("mid_rdy_before_rst", rdy_a, 0);
    rst = 1;
    tick();
    check("mid_rst_rdy", rdy_a, 0);
    rst = 0;
    sweep_count(na, nb);
    check("mid_rst_edges_a", na, 64);
    check("mid_rst_edges_b", nb, 20);
    addr_a = 9; #1; check("mid_rst_addr9", out_a, 0);
`else
    // Reset leaves memory alone and overrides load
    rst = 1; load_a = 1; addr_a = 7; din_a = 16'hFFFF;
    tick();
    check("nrst_rdy", rdy_a, 0);
    check("nrst_out", out_a, 0);
    tick();
    check("nrst_hold_rdy", rdy_a, 0);
    rst = 0; addr_a = 0; din_a = 16'h1234;
    tick();
    check("nrel_rdy", rdy_a, 1);
    check("nrel_addr0_unwritten", out_a, 16'hAAAA);
    load_a = 0; addr_a = 7;
    #1;
    check("nrel_addr7", out_a, 16'h0042);
    clr_a = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("nclr%0d_rdy", i), rdy_a, 1);
      check($sformatf("nclr%0d_addr7", i), out_a, 16'h0042);
    end
    clr_a = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_clr.md
RAM_CLR -- requirements
Module: ram_clr

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits.
REQ-002 Parameter ADDR_BITS, default 6: address port width.
REQ-003 Parameter DEPTH, default 64: number of implemented words; legal range 1..2**ADDR_BITS.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 clear  input  1  request a full-memory clear sweep.
REQ-007 load  input  1  write enable.
REQ-008 address  input  ADDR_BITS  read/write word address.
REQ-009 in  input  WIDTH  write data.
REQ-010 out  output  WIDTH  read data for address.
REQ-011 ready  output  1  high when idle and accepting reads/writes.

Function
REQ-012 Read SHALL be combinational: out = mem[address] while ready=1 and address<DEPTH; otherwise out = 0.
REQ-013 Write SHALL occur at a rising edge when load=1, ready=1, clear=0, reset=0 and address<DEPTH; it SHALL set mem[address] <= in, with out showing the new value after that edge.
REQ-014 A write to address>=DEPTH SHALL be dropped without affecting any word.
REQ-015 The FSM SHALL have two states: IDLE (ready=1) and SWEEP (ready=0).
REQ-016 IDLE->SWEEP SHALL occur on an edge with clear=1, and the pointer SHALL be set to 0; load in that cycle SHALL be ignored, so clear wins.
REQ-017 In SWEEP, each edge SHALL write 0 to mem[ptr] and increment ptr.
REQ-018 SWEEP->IDLE SHALL occur on the edge that clears mem[DEPTH-1]; ready SHALL be 1 from that edge on.
REQ-019 A sweep SHALL take exactly DEPTH edges.
REQ-020 clear asserted during SWEEP SHALL be ignored; the sweep SHALL neither restart nor extend.
REQ-021 load and address SHALL be ignored during SWEEP.
REQ-022 ptr SHALL be ceil(log2(DEPTH+1)) bits wide and SHALL NOT wrap within a sweep.

Reset
REQ-023 An edge with reset=1 SHALL force state SWEEP, ptr=0, ready=0 and out=0, overriding clear and load.
REQ-024 While reset is held, ptr SHALL stay at 0.
REQ-025 After reset is released, the sweep SHALL run per REQ-017..019; ready SHALL rise DEPTH edges after the first edge with reset=0.
REQ-026 Reset asserted mid-sweep SHALL restart the sweep from ptr=0.

Configuration
REQ-027 Macro RAM_CLR_SWEEP_EN SHALL compile the SWEEP state, the pointer and the clear port function in or out.
REQ-028 With RAM_CLR_SWEEP_EN defined, behaviour SHALL be as REQ-015..026.
REQ-029 Without RAM_CLR_SWEEP_EN:
- reset SHALL clear only ready, to 0;
- ready SHALL be 1 from the first edge with reset=0;
- memory contents SHALL be untouched by reset;
- clear SHALL be ignored;
- the port list SHALL be unchanged.

Structure
REQ-030 A shared include file ram_defs.vh SHALL hold the FSM state encodings (IDLE, SWEEP) and the default WIDTH, ADDR_BITS and DEPTH constants, for reuse by future RAM variants.
REQ-031 The FSM and pointer SHALL live in sub-module ram_clr_ctrl, with outputs ready, sweep_we and sweep_addr.
REQ-032 ram_clr SHALL contain the storage array, the write-port mux and the read mux.

Verification
REQ-033 Defaults; reset 2 cycles then release -> ready=0 for exactly 64 edges then 1; every address reads 0x0000.
REQ-034 After ready, load=1, address=5, in=0x1234 -> out=0x1234 after the edge; address=6 still reads 0x0000.
REQ-035 DEPTH=20, ADDR_BITS=6: write address 19=0xBEEF then address 25=0xDEAD -> address 19 reads 0xBEEF; address 25 reads 0x0000; no word altered.
REQ-036 clear=1 and load=1 in the same cycle (address 3, in 0x00FF) -> sweep starts; after 64 edges address 3 reads 0x0000; clear re-pulsed mid-sweep -> ready still rises exactly 64 edges after the first clear.
REQ-037 Reset pulsed at sweep edge 30 -> sweep restarts; ready rises 64 edges after reset release.
REQ-038 Without RAM_CLR_SWEEP_EN: write address 7=0x0042, pulse reset -> ready=1 one edge after release; address 7 still reads 0x0042; clear has no effect.
